// File: rtl/eq_coef_spi_bank.sv
// SPI-loaded EQ coefficient bank: oversamples sck/sdi/ce, deserialises NUM_BANDS words, commits atomically.
// Optional readback of the live bank on sdo when EQ_COEF_READBACK_EN is defined.
module eq_coef_spi_bank #(
    parameter int NUM_BANDS   = 4,
    parameter int COEF_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        sck,
    input  logic                        sdi,
    input  logic                        ce,
    output logic                        sdo,
    output logic [NUM_BANDS*COEF_W-1:0] coefs,
    output logic                        coef_valid,
    output logic                        frame_err,
    output logic                        busy
);

    localparam int BANK_W = NUM_BANDS * COEF_W;
    localparam int BC_W   = $clog2(COEF_W);
    localparam int WI_W   = $clog2(NUM_BANDS + 1);
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(COEF_W - 1);
    localparam logic [WI_W-1:0] WORD_END = WI_W'(NUM_BANDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t state_r, state_next;

    logic [SYNC_STAGES-1:0] sck_sync_r, sdi_sync_r, ce_sync_r;
    logic                   sck_s, sdi_s, ce_s;
    logic                   sck_d_r, ce_d_r;
    logic                   sck_rise_s, ce_rise_s, ce_fall_s;

    logic [BC_W-1:0]   bit_cnt_r;
    logic [WI_W-1:0]   word_idx_r;
    logic              ovf_r;
    logic              rise_pend_r;
    logic [COEF_W-1:0] shift_r;
    logic [COEF_W-1:0] word_s;
    logic [BANK_W-1:0] staging_r;
    logic [BANK_W-1:0] coefs_r;
    logic              coef_valid_r, frame_err_r, busy_r;

    logic start_s, shift_s, ovf_s, fail_s, frame_ok_s;

    // Synchroniser chains plus one extra stage for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_sync_r <= {SYNC_STAGES{1'b0}};
            sdi_sync_r <= {SYNC_STAGES{1'b0}};
            ce_sync_r  <= {SYNC_STAGES{1'b0}};
            sck_d_r    <= 1'b0;
            ce_d_r     <= 1'b0;
        end else begin
            sck_sync_r <= {sck_sync_r[SYNC_STAGES-2:0], sck};
            sdi_sync_r <= {sdi_sync_r[SYNC_STAGES-2:0], sdi};
            ce_sync_r  <= {ce_sync_r[SYNC_STAGES-2:0], ce};
            sck_d_r    <= sck_s;
            ce_d_r     <= ce_s;
        end
    end

    assign sck_s      = sck_sync_r[SYNC_STAGES-1];
    assign sdi_s      = sdi_sync_r[SYNC_STAGES-1];
    assign ce_s       = ce_sync_r[SYNC_STAGES-1];
    assign sck_rise_s = sck_s & ~sck_d_r;
    assign ce_rise_s  = ce_s & ~ce_d_r;
    assign ce_fall_s  = ~ce_s & ce_d_r;
    assign word_s     = {shift_r[COEF_W-2:0], sdi_s};
    assign frame_ok_s = (word_idx_r == WORD_END) && (bit_cnt_r == {BC_W{1'b0}}) && !ovf_r;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next;
        end
    end

    // Next-state and datapath strobes; a ce fall masks a coincident sck rise
    always_comb begin
        state_next = state_r;
        start_s    = 1'b0;
        shift_s    = 1'b0;
        ovf_s      = 1'b0;
        fail_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (ce_rise_s || rise_pend_r) begin
                    start_s    = 1'b1;
                    state_next = SHIFT;
                end else begin
                    state_next = IDLE;
                end
            end
            SHIFT: begin
                if (ce_fall_s) begin
                    if (frame_ok_s) begin
                        state_next = COMMIT;
                    end else begin
                        fail_s     = 1'b1;
                        state_next = IDLE;
                    end
                end else if (sck_rise_s) begin
                    if (word_idx_r != WORD_END) begin
                        shift_s = 1'b1;
                    end else begin
                        ovf_s = 1'b1;
                    end
                end else begin
                    state_next = SHIFT;
                end
            end
            COMMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Deserialiser, staging bank and counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt_r  <= {BC_W{1'b0}};
            word_idx_r <= {WI_W{1'b0}};
            ovf_r      <= 1'b0;
            shift_r    <= {COEF_W{1'b0}};
            staging_r  <= {BANK_W{1'b0}};
        end else if (start_s) begin
            bit_cnt_r  <= {BC_W{1'b0}};
            word_idx_r <= {WI_W{1'b0}};
            ovf_r      <= 1'b0;
        end else if (shift_s) begin
            shift_r <= word_s;
            if (bit_cnt_r == BIT_LAST) begin
                bit_cnt_r  <= {BC_W{1'b0}};
                word_idx_r <= word_idx_r + 1'b1;
                for (int k = 0; k < NUM_BANDS; k++) begin
                    if (word_idx_r == WI_W'(k)) begin
                        staging_r[k*COEF_W +: COEF_W] <= word_s;
                    end
                end
            end else begin
                bit_cnt_r <= bit_cnt_r + 1'b1;
            end
        end else if (ovf_s) begin
            ovf_r <= 1'b1;
        end
    end

    // Live bank and status outputs; a ce rise seen during COMMIT is replayed in IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            coefs_r      <= {BANK_W{1'b0}};
            coef_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            busy_r       <= 1'b0;
            rise_pend_r  <= 1'b0;
        end else begin
            coef_valid_r <= (state_r == COMMIT);
            busy_r       <= (state_next == SHIFT);
            rise_pend_r  <= (state_r == COMMIT) && ce_rise_s;
            if (state_r == COMMIT) begin
                coefs_r     <= staging_r;
                frame_err_r <= 1'b0;
            end else if (fail_s) begin
                frame_err_r <= 1'b1;
            end
        end
    end

    assign coefs      = coefs_r;
    assign coef_valid = coef_valid_r;
    assign frame_err  = frame_err_r;
    assign busy       = busy_r;

`ifdef EQ_COEF_READBACK_EN
    logic              sck_fall_s;
    logic [BANK_W-1:0] rb_r, rb_next_s, rb_load_s;
    logic              sdo_r;

    assign sck_fall_s = ~sck_s & sck_d_r;

    // Band 0 is placed at the top so it leaves first, MSB first
    always_comb begin
        rb_load_s = {BANK_W{1'b0}};
        for (int k = 0; k < NUM_BANDS; k++) begin
            rb_load_s[(NUM_BANDS-1-k)*COEF_W +: COEF_W] = coefs_r[k*COEF_W +: COEF_W];
        end
        if (start_s) begin
            rb_next_s = rb_load_s;
        end else if ((state_r == SHIFT) && sck_fall_s) begin
            rb_next_s = {rb_r[BANK_W-2:0], 1'b0};
        end else begin
            rb_next_s = rb_r;
        end
    end

    // Readback shift register and registered sdo
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rb_r  <= {BANK_W{1'b0}};
            sdo_r <= 1'b0;
        end else begin
            rb_r  <= rb_next_s;
            sdo_r <= (state_next == SHIFT) && rb_next_s[BANK_W-1];
        end
    end

    assign sdo = sdo_r;
`else
    assign sdo = 1'b0;
`endif

endmodule

// File: tb/tb_eq_coef_spi_bank.sv
// Self-checking bench for eq_coef_spi_bank: directed plan frames plus randomized frames against a bank model.
module tb_eq_coef_spi_bank;
    localparam int NB   = 4;
    localparam int CW   = 16;
    localparam int BW   = NB * CW;
    localparam int SYNC = 2;
    localparam int HALF = 6;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          sck = 1'b0;
    logic          sdi = 1'b0;
    logic          ce = 1'b0;
    logic          sdo;
    logic [BW-1:0] coefs;
    logic          coef_valid, frame_err, busy;

    eq_coef_spi_bank #(.NUM_BANDS(NB), .COEF_W(CW), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .ce(ce),
        .sdo(sdo), .coefs(coefs), .coef_valid(coef_valid),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int       n_vec = 0;
    int       n_err = 0;
    int       cyc = 0;
    int       cv_cnt = 0;
    int       cv_cyc = 0;
    int       ce_fall_cyc = 0;
    logic     sdo_hi = 1'b0;
    logic [127:0] rb_cap;
    logic [BW-1:0] m_coefs = '0;
    logic     m_err = 1'b0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (coef_valid) begin
            cv_cnt++;
            cv_cyc = cyc;
        end
        if (sdo) sdo_hi = 1'b1;
    end

    // First word on the wire is band 0
    function automatic logic [BW-1:0] frame_to_bank(input logic [127:0] d);
        logic [BW-1:0] b;
        for (int k = 0; k < NB; k++) b[k*CW +: CW] = d[BW-1-k*CW -: CW];
        return b;
    endfunction

    function automatic logic exp_rb_bit(input logic [BW-1:0] bank, input int i);
        if (i >= BW) return 1'b0;
        return bank[(i / CW) * CW + CW - 1 - (i % CW)];
    endfunction

    task automatic model_frame(input int nbits, input logic [127:0] d);
        if (nbits == BW) begin
            m_coefs = frame_to_bank(d);
            m_err   = 1'b0;
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic send_frame(input int nbits, input logic [127:0] d, input int abort_at);
        logic aborted;
        aborted = 1'b0;
        rb_cap  = '0;
        ce      = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            if (i == abort_at) begin
                reset = 1'b0;
                ce    = 1'b0;
                sck   = 1'b0;
                repeat (3) @(negedge clk);
                reset   = 1'b1;
                aborted = 1'b1;
                break;
            end
            sdi = d[nbits-1-i];
            repeat (HALF) @(negedge clk);
            rb_cap = {rb_cap[126:0], sdo};
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
        if (!aborted) begin
            repeat (HALF) @(negedge clk);
            ce = 1'b0;
            ce_fall_cyc = cyc;
        end
    endtask

    task automatic check_after(input string name, input int nbits, input logic [BW-1:0] old_bank,
                               input int cv_base, input int exp_cv, input logic do_rb);
        int lat, bad;
        repeat (12) @(negedge clk);
        n_vec++;
        if (coefs !== m_coefs) begin
            n_err++;
            $display("FAIL %s coefs: got %h expected %h", name, coefs, m_coefs);
        end
        n_vec++;
        if (frame_err !== m_err) begin
            n_err++;
            $display("FAIL %s frame_err: got %b expected %b", name, frame_err, m_err);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s busy: got %b expected 0", name, busy);
        end
        n_vec++;
        if ((cv_cnt - cv_base) != exp_cv) begin
            n_err++;
            $display("FAIL %s coef_valid pulses: got %0d expected %0d", name, cv_cnt - cv_base, exp_cv);
        end
        if (exp_cv > 0) begin
            lat = cv_cyc - ce_fall_cyc;
            n_vec++;
            if (lat < 1 || lat > SYNC + 3) begin
                n_err++;
                $display("FAIL %s latency: got %0d clk expected 1..%0d", name, lat, SYNC + 3);
            end
        end
`ifdef EQ_COEF_READBACK_EN
        if (do_rb) begin
            bad = 0;
            for (int i = 0; i < nbits; i++)
                if (rb_cap[nbits-1-i] !== exp_rb_bit(old_bank, i)) bad++;
            n_vec++;
            if (bad != 0) begin
                n_err++;
                $display("FAIL %s readback: got %0d wrong bits expected 0 (captured %h)", name, bad, rb_cap);
            end
        end
`else
        bad = (do_rb && nbits > 0 && old_bank != '0) ? 0 : 0;
        n_vec++;
        if (sdo_hi !== 1'b0) begin
            n_err++;
            $display("FAIL %s sdo_tied: got sdo high expected 0 (%0d)", name, bad);
        end
`endif
    endtask

    task automatic do_frame(input string name, input int nbits, input logic [127:0] d);
        logic [BW-1:0] old_bank;
        int base;
        old_bank = m_coefs;
        base     = cv_cnt;
        send_frame(nbits, d, -1);
        model_frame(nbits, d);
        check_after(name, nbits, old_bank, base, (nbits == BW) ? 1 : 0, 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({coefs, coef_valid, frame_err, busy, sdo} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got coefs=%h cv=%b err=%b busy=%b sdo=%b expected all 0",
                     coefs, coef_valid, frame_err, busy, sdo);
        end
    endtask

    task automatic test_single_frame();
        do_frame("single", BW, 128'h1111_2222_3333_4444);
    endtask

    task automatic test_short_frame();
        do_frame("short48", 48, 128'h9999_8888_7777);
        do_frame("good_after_short", BW, 128'hAAAA_BBBB_CCCC_DDDD);
    endtask

    task automatic test_overflow();
        do_frame("over65", 65, {$urandom, $urandom, $urandom, $urandom});
        do_frame("under63", 63, {$urandom, $urandom, $urandom, $urandom});
    endtask

    task automatic test_reset_midframe();
        send_frame(BW, 128'h5555_6666_7777_8888, 30);
        m_coefs = '0;
        m_err   = 1'b0;
        check_after("reset_mid", 0, m_coefs, cv_cnt, 0, 1'b0);
        do_frame("after_reset", BW, 128'h0001_0002_0003_0004);
    endtask

    task automatic test_back_to_back();
        logic [127:0] d1, d2;
        int base;
        d1   = {64'h0, $urandom, $urandom};
        d2   = {64'h0, $urandom, $urandom};
        base = cv_cnt;
        send_frame(BW, d1, -1);
        repeat (4) @(negedge clk);
        send_frame(BW, d2, -1);
        model_frame(BW, d1);
        model_frame(BW, d2);
        check_after("back_to_back", BW, m_coefs, base, 2, 1'b0);
    endtask

    task automatic test_readback();
        do_frame("rb_load", BW, 128'h1111_2222_3333_4444);
        do_frame("rb_zero", BW, 128'h0);
    endtask

    task automatic test_random();
        int nbits;
        for (int n = 0; n < 14; n++) begin
            nbits = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 80) : BW;
            do_frame("random", nbits, {$urandom, $urandom, $urandom, $urandom});
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_short_frame();
        test_overflow();
        test_reset_midframe();
        test_back_to_back();
        test_readback();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/eq_coef_spi_bank.md
Name: eq_coef_spi_bank

Overview:
- Parametrised successor to the single-word SPI equaliser value shifter.
- Oversamples an external SPI link (sck, sdi, ce) in the system clock domain.
- Deserialises a frame of NUM_BANDS coefficients of COEF_W bits each.
- Atomically commits a complete frame to a live coefficient bank that feeds the EQ/MAC datapath. Malformed frames are rejected and the live bank is left untouched.

Parameters:
- NUM_BANDS, 4, number of EQ band coefficients per frame (>=1).
- COEF_W, 16, bits per coefficient (2..32).
- SYNC_STAGES, 2, synchroniser depth for sck/sdi/ce (>=2).

Ports:
- clk  in  1  system clock (12 MHz HSOSC); the only clock.
- reset  in  1  active-low asynchronous reset.
- sck  in  1  SPI clock, asynchronous to clk; sampled only.
- sdi  in  1  SPI data, MSB first.
- ce  in  1  chip enable, active high; frame = one ce-high window.
- sdo  out  1  readback data (see Optional Feature).
- coefs  out  NUM_BANDS*COEF_W  live bank; band k at [k*COEF_W +: COEF_W].
- coef_valid  out  1  one-cycle pulse when a new bank is committed.
- frame_err  out  1  sticky error flag.
- busy  out  1  high while a frame is in progress (state SHIFT).

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. clk and reset are the port names.
- Timing requirement: clk >= 4x sck frequency. Minimum sck high and low time is 2 clk each.
- Synchronisation:
  - sck, sdi and ce each pass through SYNC_STAGES flops, giving sck_s, sdi_s, ce_s.
  - One further register on sck_s and on ce_s provides edge detection (rise/fall).
- Reset values: coefs=0, coef_valid=0, frame_err=0, busy=0, sdo=0. Staging bank, shift register and counters are 0; FSM is in IDLE.
- Counters:
  - bit_cnt runs 0..COEF_W-1.
  - word_idx runs 0..NUM_BANDS.
  - overflow flag is set on any sck rise when word_idx==NUM_BANDS.
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: on ce_s rise, clear bit_cnt, word_idx and overflow, then go to SHIFT. busy=1 from the next cycle.
  - SHIFT, on each sck_s rise:
    - If word_idx<NUM_BANDS: shift sdi_s into the shift register LSB end (MSB-first word). Increment bit_cnt.
    - When bit_cnt==COEF_W-1: write the completed word to staging[word_idx], increment word_idx, and wrap bit_cnt to 0.
    - Otherwise (word_idx==NUM_BANDS): set overflow; the bit is discarded.
  - SHIFT, on ce_s fall:
    - If word_idx==NUM_BANDS, bit_cnt==0 and !overflow: go to COMMIT.
    - Otherwise: set frame_err=1 and return to IDLE. coefs is unchanged and no coef_valid pulse is issued.
  - COMMIT: coefs <= staging, coef_valid=1 for exactly this one cycle, frame_err cleared to 0, then go to IDLE.
- Band ordering: the first word shifted in is band 0.
- Latency: coefs and coef_valid update at most SYNC_STAGES+3 clk after the raw ce falling edge.
- Simultaneous events:
  - An sck_s rise in the same cycle as a ce_s fall is ignored (the bit is not counted).
  - A ce_s rise during COMMIT is acted on in the following IDLE cycle; no bit is lost, provided the timing requirement above is met.
- Reset mid-frame: the partial frame is discarded and all outputs return to their reset values (coefs=0).
- frame_err is sticky; only a successful commit or a reset clears it.
- coefs is stable between commits. The downstream datapath may sample coefs at any time; it never observes a half-written bank.

Optional Feature:
- Macro: EQ_COEF_READBACK_EN.
- Defined:
  - On ce_s rise, a readback shift register loads the current coefs.
  - sdo presents band 0 MSB first. It advances one bit on each sck_s fall while in SHIFT, so the host reads the old bank while writing the new one.
  - sdo=0 when not in SHIFT.
  - Readback data beyond NUM_BANDS*COEF_W bits is 0.
- Not defined: sdo is tied to 0 and the readback register is not built.

Test Plan (NUM_BANDS=4, COEF_W=16, clk=12 MHz, sck=1 MHz):
1. Release reset, then send one 64-bit frame 0x1111_2222_3333_4444 -> coefs band0=0x1111, band1=0x2222, band2=0x3333, band3=0x4444; one coef_valid pulse within 5 clk of ce fall; frame_err=0; busy low after the frame.
2. After test 1, send a 48-bit frame -> frame_err=1, coefs unchanged, no coef_valid. Then send a good frame 0xAAAA_BBBB_CCCC_DDDD -> coefs updated, frame_err=0.
3. Send a 65-bit frame -> overflow detected, frame_err=1, coefs unchanged. Repeat with a 63-bit frame -> same result.
4. Assert reset at bit 30 of a frame -> coefs=0, busy=0, frame_err=0. A following good frame 0x0001_0002_0003_0004 commits correctly.
5. Send two good frames back-to-back with ce low for 4 clk between them -> two coef_valid pulses; final coefs equal the second frame.
6. With EQ_COEF_READBACK_EN, after test 1, send frame 0 -> sdo streams 0x1111, 0x2222, 0x3333, 0x4444 MSB first; coefs become 0 after commit. Without the macro, sdo stays 0 throughout.
